seq_chunk_adder: RTL and testbench



---
 rtl/seq_adder_pkg.sv | 32 +++
 rtl/seq_chunk_adder_rca_chunk.sv | 33 +++
 rtl/seq_chunk_adder.sv | 184 ++++++++++++++++++
 tb/tb_seq_chunk_adder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared state encoding and sizing helpers for seq_chunk_adder
//
// Contents:
//   IDLE/BUSY/DONE  2-bit state encodings
//   state_t         FSM state enum built on those encodings
//   calc_nchunk()   number of chunks a WIDTH-bit add is split into
//   calc_idx_w()    width of the chunk index register (minimum 1)
package seq_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_BUSY = BUSY,
        S_DONE = DONE
    } state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    // A single-chunk configuration still gets a 1-bit index so the
    // register and its compare stay well formed.
    function automatic int calc_idx_w(input int width, input int chunk);
        int n;
        n = calc_nchunk(width, chunk);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// rtl/seq_chunk_adder_rca_chunk.sv - combinational CHUNK-bit ripple-carry adder slice
//
// Ports:
//   a, b   [CHUNK]  operand slices
//   cin    1        carry into bit 0
//   sum    [CHUNK]  slice sum
//   cout   1        carry out of the slice MSB
//   c_msb  1        carry into the slice MSB (feeds signed overflow detection)
module rca_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin : p_ripple
        logic [CHUNK:0] c;
        c     = '0;
        sum   = '0;
        c[0]  = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout  = c[CHUNK];
        c_msb = c[CHUNK-1];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked ripple-carry adder/subtractor
//
// Adds CHUNK bits per clock over WIDTH/CHUNK cycles using one rca_chunk
// slice, time-multiplexed across the operand.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   operand handshake (in_ready only in IDLE)
//   a, b [WIDTH]         operands
//   cin                  carry-in (ignored when sub=1)
//   sub                  0: a+b+cin, 1: a-b
//   out_valid, out_ready result handshake
//   sum [WIDTH]          result (meaningful only while out_valid)
//   cout                 carry out of MSB (subtract: 1 = no borrow)
//   ovf                  signed two's-complement overflow
//   zero, neg            result flags, present only with SEQ_ADDER_FLAGS_EN
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SEQ_ADDER_FLAGS_EN
    output logic             ovf,
    output logic             zero,
    output logic             neg
`else
    output logic             ovf
`endif
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(WIDTH, CHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t state, state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted for subtraction
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_c_msb;
    int               base;

    assign base    = int'(idx_q) * CHUNK;
    assign slice_a = a_q[base +: CHUNK];
    assign slice_b = b_q[base +: CHUNK];

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_rca (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (idx_q == LAST_IDX) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef SEQ_ADDER_FLAGS_EN
    logic             zero_q;
    logic             neg_q;
    logic [WIDTH-1:0] sum_full;

    // Flags must see the final chunk, which is only being written this cycle.
    always_comb begin
        sum_full                  = sum_q;
        sum_full[base +: CHUNK]   = slice_sum;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SEQ_ADDER_FLAGS_EN
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                S_BUSY: begin
                    sum_q[base +: CHUNK] <= slice_sum;
                    carry_q              <= slice_cout;
                    idx_q                <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q <= slice_cout;
                        // Overflow: carry into the word MSB differs from carry out of it.
                        ovf_q  <= slice_c_msb ^ slice_cout;
`ifdef SEQ_ADDER_FLAGS_EN
                        zero_q <= (sum_full == '0);
                        neg_q  <= sum_full[WIDTH-1];
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
`ifdef SEQ_ADDER_FLAGS_EN
    assign zero = zero_q;
    assign neg  = neg_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=8, CHUNK=2
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;
    // WIDTH=16, CHUNK=4
    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
    logic [15:0] w_a, w_b, w_sum;
    // WIDTH=8, CHUNK=8
    logic       s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [7:0] s_a, s_b, s_sum;
`ifdef SEQ_ADDER_FLAGS_EN
    logic zero, neg, w_zero, w_neg, s_zero, s_neg;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout),
`ifdef SEQ_ADDER_FLAGS_EN
        .ovf(ovf), .zero(zero), .neg(neg)
`else
        .ovf(ovf)
`endif
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout),
`ifdef SEQ_ADDER_FLAGS_EN
        .ovf(w_ovf), .zero(w_zero), .neg(w_neg)
`else
        .ovf(w_ovf)
`endif
    );

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .sum(s_sum), .cout(s_cout),
`ifdef SEQ_ADDER_FLAGS_EN
        .ovf(s_ovf), .zero(s_zero), .neg(s_neg)
`else
        .ovf(s_ovf)
`endif
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       s;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    // Issue one operation on the 8/2 instance; returns cycles from the accept
    // edge to out_valid (capped at 20).
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                         input logic ts, output int lat);
        @(negedge clk);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'hA5; b = 8'h3C; cin = 1'b1; sub = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({sum, cout, ovf, out_valid, in_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: sum=%h cout=%b ovf=%b ov=%b ir=%b required 00 0 0 0 1",
                     sum, cout, ovf, out_valid, in_ready);
        end
`ifdef SEQ_ADDER_FLAGS_EN
        n_checks++;
        if ({zero, neg} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: zero=%b neg=%b required 0 0", zero, neg);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors;
        vec_t v[6];
        int lat;
        v[0] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
        v[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        v[2] = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
        v[3] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        v[4] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        v[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            do_op(v[i].a, v[i].b, v[i].c, v[i].s, lat);
            n_checks++;
            if (lat !== 4) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d required 4", i, lat);
            end
            n_checks++;
            if ({sum, cout, ovf} !== {v[i].es, v[i].ec, v[i].eo}) begin
                n_fail++;
                $display("FAIL vec%0d_result: sum=%h cout=%b ovf=%b required %h %b %b",
                         i, sum, cout, ovf, v[i].es, v[i].ec, v[i].eo);
            end
`ifdef SEQ_ADDER_FLAGS_EN
            n_checks++;
            if ({zero, neg} !== {v[i].es == 8'h00, v[i].es[7]}) begin
                n_fail++;
                $display("FAIL vec%0d_flags: zero=%b neg=%b required %b %b",
                         i, zero, neg, v[i].es == 8'h00, v[i].es[7]);
            end
`endif
            drain();
        end
    endtask

    task automatic test_back_pressure;
        int lat;
        do_op(8'h03, 8'h04, 1'b0, 1'b0, lat);
        in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({sum, cout, ovf, out_valid, in_ready} !== {8'h07, 1'b0, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: sum=%h cout=%b ovf=%b ov=%b ir=%b required 07 0 0 1 0",
                         i, sum, cout, ovf, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_idle: ov=%b ir=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (sum !== 8'h33 || lat !== 4) begin
            n_fail++;
            $display("FAIL after_release: sum=%h lat=%0d required 33 4", sum, lat);
        end
        drain();
    endtask

    task automatic test_reset_mid_busy;
        int lat;
        @(negedge clk);
        a = 8'h55; b = 8'h11; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || sum !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: ov=%b sum=%h ir=%b required 0 00 1", out_valid, sum, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(8'h10, 8'h20, 1'b0, 1'b0, lat);
        n_checks++;
        if (sum !== 8'h30 || cout !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL post_reset_op: sum=%h cout=%b lat=%0d required 30 0 4", sum, cout, lat);
        end
        drain();
    endtask

    task automatic test_wide;
        int lat;
        @(negedge clk);
        w_a = 16'hF0F0; w_b = 16'h0F0F; w_cin = 1'b1; w_sub = 1'b0; w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        lat = 0;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if ({w_sum, w_cout, w_ovf} !== {16'h0000, 1'b1, 1'b0} || lat !== 4) begin
            n_fail++;
            $display("FAIL wide_16x4: sum=%h cout=%b ovf=%b lat=%0d required 0000 1 0 4",
                     w_sum, w_cout, w_ovf, lat);
        end
        w_out_ready = 1'b1;
        @(posedge clk);
        #1;
        w_out_ready = 1'b0;
    endtask

    task automatic test_single_chunk;
        int lat;
        @(negedge clk);
        s_a = 8'h7F; s_b = 8'h01; s_cin = 1'b0; s_sub = 1'b0; s_in_valid = 1'b1;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if ({s_sum, s_cout, s_ovf} !== {8'h80, 1'b0, 1'b1} || lat !== 1) begin
            n_fail++;
            $display("FAIL single_8x8: sum=%h cout=%b ovf=%b lat=%0d required 80 0 1 1",
                     s_sum, s_cout, s_ovf, lat);
        end
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0; s_out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_back_pressure();
        test_reset_mid_busy();
        test_wide();
        test_single_chunk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
